fib_operand_stack: RTL and testbench
====================================

Name: fib_operand_stack

Overview:
- 64-bit LIFO operand stack holding intermediate Fibonacci terms and recursion arguments.
- Sits directly upstream of the datapath operand selection stage; its registered top-of-stack is one candidate input to the 64-bit select muxes.
- The controller FSM issues push/pop strobes. The selected datapath result comes back through din for pushes.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 16, number of stack entries (power of two, at least 2).
- CW, $clog2(DEPTH), pointer width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- push  input  1  write din onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- din  input  WIDTH  data to push.
- top  output  WIDTH  registered current top-of-stack value; 0 when empty.
- count  output  CW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  one-cycle pulse: push rejected because full.
- underflow  output  1  one-cycle pulse: pop rejected because empty.
- hwm  output  CW+1  high-water mark of count (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n low, asynchronous):
  - top=0, count=0, empty=1, full=0, overflow=0, underflow=0, hwm=0.
  - Storage array is not cleared; it is unreachable until rewritten.
- Reset asserted mid-operation: any in-flight push/pop is discarded. The first accepted operation is on the first rising edge with rst_n high.
- All outputs are registered and change only on the rising clk edge. Latency is one cycle: after an edge with an accepted op, top/count/flags reflect the new state.
- Operations by {push,pop} and state:
  - 00: hold all state; overflow and underflow return to 0.
  - 10, not full: mem[count] <= din; count+1; top <= din.
  - 10, full: no state change; overflow=1 for one cycle.
  - 01, not empty: count-1. top <= mem[count-2] if count >= 2, else top <= 0.
  - 01, empty: no state change; underflow=1 for one cycle.
  - 11, not empty (including full): replace the top. mem[count-1] <= din; top <= din; count unchanged; no flag.
  - 11, empty: treated as plain push. mem[0] <= din; count=1; top <= din; no underflow.
- Derived flags:
  - empty and full are registered alongside count and stay consistent with it every cycle.
  - overflow and underflow are never both 1.
- Arithmetic and pointer:
  - count never wraps: it stays within 0..DEPTH in all sequences.
  - The write/read pointer is count[CW-1:0]. Index wrap at DEPTH is unreachable because pushes at full are rejected.
- No combinational path from push/pop/din to any output.

Optional Feature:
- Macro: FIB_STACK_HWM_EN.
- Defined:
  - hwm is a register holding the maximum count reached since reset.
  - Updated on the same edge as count: hwm <= max(hwm, next count).
  - Reset to 0 by rst_n only; pops never lower it.
- Not defined:
  - hwm tied to constant 0.
  - No extra registers or comparator synthesized; port list unchanged.

Test Plan:
- Reset, then push 64'd1, 64'd1, 64'd2 on consecutive cycles -> top=1,1,2 each following cycle; count=3; empty=0.
- From count=3 (1,1,2), pop three times -> top=1, then 1, then 0; count=0; empty=1; no underflow. A fourth pop -> underflow pulse exactly one cycle; count stays 0.
- With DEPTH=16, push values 0..15 -> full=1, top=15. Push 64'hDEAD -> overflow one cycle, top=15, count=16. Then push+pop with 64'hBEEF -> top=64'hBEEF, count=16, no flags.
- Push+pop with 64'd5 while empty -> count=1, top=5, underflow=0. Push+pop with 64'd8 -> count=1, top=8.
- Push 64'd3, 64'd4; assert rst_n low mid-cycle while push=1 -> outputs go to 0 immediately without a clock edge. After release, pop -> underflow pulse.
- FIB_STACK_HWM_EN defined: push 5 entries, pop 3, push 1 -> hwm=5, count=3. Undefined: same sequence -> hwm=0 throughout.

Source files
------------

// File: rtl/fib_operand_stack.sv
// fib_operand_stack
//   LIFO operand stack for the Fibonacci datapath. It holds intermediate terms
//   and recursion arguments. Its registered top-of-stack feeds the operand
//   select muxes directly.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   push      write din onto the stack this cycle
//   pop       remove the top entry this cycle
//   din       data to push (the selected datapath result)
//   top       registered top-of-stack value, 0 when empty
//   count     number of valid entries, 0..DEPTH
//   empty     count == 0 (registered)
//   full      count == DEPTH (registered)
//   overflow  one-cycle pulse: a push was rejected because the stack was full
//   underflow one-cycle pulse: a pop was rejected because the stack was empty
//   hwm       high-water mark of count since reset
//
// Optional feature
//   FIB_STACK_HWM_EN  When defined, hwm tracks the maximum count reached.
//                     When undefined, hwm is tied to 0 and no logic is built.
//
// Strobe semantics: push and pop are single-cycle command strobes. There is
// no ready/back-pressure. Every strobe is acted on at the next rising edge,
// and its effect is visible on the outputs right after that edge. A push at
// full is dropped and reported on overflow. A pop at empty is dropped and
// reported on underflow. push+pop together replaces the top entry, or acts as
// a plain push when the stack is empty.

module fib_operand_stack #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [CW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   output logic [CW:0]      hwm
);

   localparam logic [CW:0] COUNT_ONE  = (CW+1)'(1);
   localparam logic [CW:0] COUNT_TWO  = (CW+1)'(2);
   localparam logic [CW:0] COUNT_FULL = (CW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH-1:0] top_q, top_d;
   logic [CW:0]      count_q, count_d;
   logic             empty_q, full_q;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_en;
   logic [CW-1:0]    wr_idx;
   logic [CW-1:0]    rd_idx;

   // Entry that becomes the new top after a pop. When count is DEPTH, the low
   // bits of count are 0, so the modulo subtraction still lands on DEPTH-2.
   assign rd_idx = count_q[CW-1:0] - CW'(2);

   always_comb begin
      count_d = count_q;
      top_d   = top_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = count_q[CW-1:0];
      case ({push, pop})
         2'b10: begin
            if (full_q) begin
               ovf_d = 1'b1;
            end else begin
               wr_en   = 1'b1;
               count_d = count_q + COUNT_ONE;
               top_d   = din;
            end
         end
         2'b01: begin
            if (empty_q) begin
               unf_d = 1'b1;
            end else begin
               count_d = count_q - COUNT_ONE;
               top_d   = (count_q >= COUNT_TWO) ? mem[rd_idx] : '0;
            end
         end
         2'b11: begin
            wr_en = 1'b1;
            top_d = din;
            if (empty_q) begin
               wr_idx  = '0;
               count_d = COUNT_ONE;
            end else begin
               // Replace the top. Modulo arithmetic also covers the full case.
               wr_idx = count_q[CW-1:0] - CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q   <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == COUNT_FULL);
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // The storage array has no reset. Entries above count are never read
   // before they are rewritten. Writes are blocked while reset is held, so a
   // strobe present during reset leaves no trace.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
         mem[wr_idx] <= din;
      end
   end

`ifdef FIB_STACK_HWM_EN
   logic [CW:0] hwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else if (count_d > hwm_q) begin
         hwm_q <= count_d;
      end
   end

   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

   assign top       = top_q;
   assign count     = count_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_fib_operand_stack.sv
// tb_fib_operand_stack
//   Directed bench for fib_operand_stack. It keeps a queue model of the stack
//   and compares every output at each falling edge. Literal expectations at
//   key points pin the model itself.

module tb_fib_operand_stack;

   localparam int WIDTH = 64;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] top;
   logic [CW:0]      count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic [CW:0]      hwm;

   int checks   = 0;
   int failures = 0;

   // Model state: the stack contents (last element is the top), the pending
   // flag pulses and the high-water mark.
   logic [WIDTH-1:0] exp_q[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   int               m_hwm = 0;

   fib_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .hwm       (hwm)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_hwm = 0;
   endtask

   task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (p && o) begin
         if (exp_q.size() == 0) exp_q.push_back(d);
         else exp_q[exp_q.size()-1] = d;
      end else if (p) begin
         if (exp_q.size() == DEPTH) m_ovf = 1'b1;
         else exp_q.push_back(d);
      end else if (o) begin
         if (exp_q.size() == 0) m_unf = 1'b1;
         else void'(exp_q.pop_back());
      end
      if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
   endtask

   // Compare all outputs against the model on every falling edge.
   always @(negedge clk) begin
      int               sz;
      logic [WIDTH-1:0] e_top;
      int               e_hwm;
      sz    = exp_q.size();
      e_top = (sz > 0) ? exp_q[sz-1] : '0;
`ifdef FIB_STACK_HWM_EN
      e_hwm = m_hwm;
`else
      e_hwm = 0;
`endif
      chk("cyc_top",       top,            e_top);
      chk("cyc_count",     64'(count),     64'(sz));
      chk("cyc_empty",     64'(empty),     64'(sz == 0));
      chk("cyc_full",      64'(full),      64'(sz == DEPTH));
      chk("cyc_overflow",  64'(overflow),  64'(m_ovf));
      chk("cyc_underflow", 64'(underflow), 64'(m_unf));
      chk("cyc_hwm",       64'(hwm),       64'(e_hwm));
      chk("cyc_flag_excl", 64'(overflow & underflow), 64'd0);
   end

   // ---------------- driver ----------------
   // Applies one command for one clock. It returns at the next falling edge,
   // when the result is visible.
   task automatic op(input logic p, input logic o, input logic [WIDTH-1:0] d);
      push = p;
      pop  = o;
      din  = d;
      @(posedge clk);
      model_step(p, o, d);
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      chk("rst_top",   top,          64'd0);
      chk("rst_count", 64'(count),   64'd0);
      chk("rst_empty", 64'(empty),   64'd1);
      chk("rst_full",  64'(full),    64'd0);
      chk("rst_hwm",   64'(hwm),     64'd0);
      rst_n = 1'b1;

      // Fibonacci seed pushes.
      op(1, 0, 64'd1); chk("p1_top", top, 64'd1);
      op(1, 0, 64'd1); chk("p2_top", top, 64'd1);
      op(1, 0, 64'd2); chk("p3_top", top, 64'd2);
      chk("p3_count", 64'(count), 64'd3);
      chk("p3_empty", 64'(empty), 64'd0);

      // Drain, then pop once more from empty.
      op(0, 1, '0); chk("q1_top", top, 64'd1);
      op(0, 1, '0); chk("q2_top", top, 64'd1);
      op(0, 1, '0); chk("q3_top", top, 64'd0);
      chk("q3_empty", 64'(empty), 64'd1);
      chk("q3_unf",   64'(underflow), 64'd0);
      op(0, 1, '0); chk("q4_unf", 64'(underflow), 64'd1);
      chk("q4_count", 64'(count), 64'd0);
      op(0, 0, '0); chk("q5_unf", 64'(underflow), 64'd0);

      // Fill to DEPTH, overflow, then replace the top while full.
      for (int i = 0; i < DEPTH; i++) op(1, 0, 64'(i));
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_top",  top, 64'd15);
      op(1, 0, 64'hDEAD);
      chk("ovf_pulse", 64'(overflow), 64'd1);
      chk("ovf_top",   top, 64'd15);
      chk("ovf_count", 64'(count), 64'd16);
      op(1, 1, 64'hBEEF);
      chk("rep_top",   top, 64'hBEEF);
      chk("rep_count", 64'(count), 64'd16);
      chk("rep_ovf",   64'(overflow), 64'd0);
      op(0, 1, '0); chk("rep_pop_top", top, 64'd14);
      for (int i = 0; i < DEPTH - 1; i++) op(0, 1, '0);
      chk("drain_empty", 64'(empty), 64'd1);

      // push+pop on empty behaves as a push.
      op(1, 1, 64'd5);
      chk("pp_empty_count", 64'(count), 64'd1);
      chk("pp_empty_top",   top, 64'd5);
      chk("pp_empty_unf",   64'(underflow), 64'd0);
      op(1, 1, 64'd8);
      chk("pp_one_count", 64'(count), 64'd1);
      chk("pp_one_top",   top, 64'd8);
      op(0, 1, '0);

      // Asynchronous reset in mid-cycle while a push is pending.
      op(1, 0, 64'd3);
      op(1, 0, 64'd4);
      push = 1'b1;
      din  = 64'd9;
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      chk("arst_top",   top, 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_empty", 64'(empty), 64'd1);
      @(negedge clk);
      push  = 1'b0;
      rst_n = 1'b1;
      op(0, 1, '0);
      chk("arst_unf", 64'(underflow), 64'd1);
      op(0, 0, '0);

      // High-water mark: push 5, pop 3, push 1.
      do_reset();
      for (int i = 0; i < 5; i++) op(1, 0, 64'(10 + i));
      for (int i = 0; i < 3; i++) op(0, 1, '0);
      op(1, 0, 64'd20);
      chk("hwm_count", 64'(count), 64'd3);
      chk("hwm_top",   top, 64'd20);
`ifdef FIB_STACK_HWM_EN
      chk("hwm_value", 64'(hwm), 64'd5);
`else
      chk("hwm_value", 64'(hwm), 64'd0);
`endif
      op(0, 1, '0); chk("hwm_pop_top", top, 64'd11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
